// File: rtl/pipe_stage_elastic_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_elastic_if
//   One direction of a pipeline-stage channel: valid/ready handshake plus an
//   opaque control bundle and a data payload.
//
// Handshake: a transfer happens on a rising clock edge where valid && ready
//   are both 1. The master keeps valid/ctrl/data stable while valid=1 and
//   ready=0. ready may be asserted independently of valid.
//
// Signals:
//   valid  master -> slave  entry valid
//   ready  slave  -> master slave accepts the entry
//   ctrl   master -> slave  control bundle  [CTRL_W-1:0]
//   data   master -> slave  payload         [DATA_W-1:0]
// -----------------------------------------------------------------------------
interface pipe_stage_elastic_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// pipe_stage_elastic
//   Generic elastic pipeline-stage register. Moves a control bundle and a
//   payload from the upstream stage to the downstream stage with a valid/ready
//   handshake, supports a synchronous flush that inserts a bubble, and keeps
//   the control bundle at zero whenever no valid entry is held.
//
// Build option:
//   PIPE_SKID_EN defined   : 2-entry skid buffer (main M + skid S); up.ready is
//                            a pure register output, full throughput.
//   PIPE_SKID_EN undefined : single register M; up.ready = !dn.valid || dn.ready.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   flush      in   synchronous flush, discards all held entries
//   up         slave  modport: up.valid/up.ctrl/up.data in, up.ready out
//   dn         master modport: dn.valid/dn.ctrl/dn.data out, dn.ready in
//   occupancy  out  number of held entries (0..2); also the FSM state encoding
//   stall_cnt  out  saturating count of cycles with dn.valid && !dn.ready
// -----------------------------------------------------------------------------
module pipe_stage_elastic #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    pipe_stage_elastic_if.slave  up,
    pipe_stage_elastic_if.master dn,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt
);
    // The encoding equals the number of held entries, so occupancy is
    // simply the state register and doubles as the FSM debug view.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic dn_valid;
    logic up_ready;
    logic do_accept;
    logic do_release;

    assign dn_valid = (state_q != EMPTY);

`ifdef PIPE_SKID_EN
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic              up_ready_q;

    assign up_ready = up_ready_q;
`else
    assign up_ready = !dn_valid || dn.ready;
`endif

    assign do_accept  = up.valid && up_ready;
    assign do_release = dn_valid && dn.ready;

    always_comb begin
        state_d  = state_q;
        m_ctrl_d = m_ctrl_q;
        m_data_d = m_data_q;
`ifdef PIPE_SKID_EN
        s_ctrl_d = s_ctrl_q;
        s_data_d = s_data_q;
`endif
        if (flush) begin
            // Offered entry is dropped; payload keeps its last value so the
            // output stays stable, control drops to the bubble value.
            state_d  = EMPTY;
            m_ctrl_d = '0;
`ifdef PIPE_SKID_EN
            s_ctrl_d = '0;
`endif
        end else begin
            case (state_q)
                EMPTY: begin
                    if (do_accept) begin
                        state_d  = ONE;
                        m_ctrl_d = up.ctrl;
                        m_data_d = up.data;
                    end
                end
                ONE: begin
                    if (do_accept && do_release) begin
                        m_ctrl_d = up.ctrl;
                        m_data_d = up.data;
`ifdef PIPE_SKID_EN
                    end else if (do_accept) begin
                        state_d  = TWO;
                        s_ctrl_d = up.ctrl;
                        s_data_d = up.data;
`endif
                    end else if (do_release) begin
                        state_d  = EMPTY;
                        m_ctrl_d = '0;
                    end
                end
`ifdef PIPE_SKID_EN
                TWO: begin
                    // up.ready is low here, so only a release can happen.
                    if (do_release) begin
                        state_d  = ONE;
                        m_ctrl_d = s_ctrl_q;
                        m_data_d = s_data_q;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (dn_valid && !dn.ready && (stall_q != {CNT_W{1'b1}}))
            stall_d = stall_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            m_ctrl_q <= '0;
            m_data_q <= '0;
            stall_q  <= '0;
`ifdef PIPE_SKID_EN
            s_ctrl_q   <= '0;
            s_data_q   <= '0;
            up_ready_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            m_ctrl_q <= m_ctrl_d;
            m_data_q <= m_data_d;
            stall_q  <= stall_d;
`ifdef PIPE_SKID_EN
            s_ctrl_q   <= s_ctrl_d;
            s_data_q   <= s_data_d;
            // Registered from the next state: no path from dn.ready.
            up_ready_q <= (state_d != TWO);
`endif
        end
    end

    assign up.ready  = up_ready;
    assign dn.valid  = dn_valid;
    assign dn.ctrl   = m_ctrl_q;
    assign dn.data   = m_data_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_q;
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_elastic
//   Directed bench for pipe_stage_elastic (DATA_W=32, CTRL_W=8, CNT_W=4).
//   Expected values are hand-computed; the skid-specific steps are selected
//   with PIPE_SKID_EN to match the build of the design.
// -----------------------------------------------------------------------------
module tb_pipe_stage_elastic;
    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;

`ifdef PIPE_SKID_EN
    localparam logic RST_UP_READY = 1'b0;
`else
    localparam logic RST_UP_READY = 1'b1;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_stage_elastic_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) up_if ();
    pipe_stage_elastic_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dn_if ();

    pipe_stage_elastic #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .up       (up_if),
        .dn       (dn_if),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] c, input logic [31:0] d);
        up_if.valid = v;
        up_if.ctrl  = c;
        up_if.data  = d;
    endtask

    // checking
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] c,
                           input logic [31:0] d, input logic [1:0] occ);
        chk({tag, ".dn_valid"}, 32'(dn_if.valid), 32'(v));
        chk({tag, ".dn_ctrl"}, 32'(dn_if.ctrl), 32'(c));
        chk({tag, ".dn_data"}, dn_if.data, d);
        chk({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
    endtask

    task automatic chk_reset(input string tag);
        chk_out(tag, 1'b0, 8'h00, 32'h0, 2'd0);
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'd0);
        chk({tag, ".up_ready"}, 32'(up_if.ready), 32'(RST_UP_READY));
    endtask

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        dn_if.ready = 1'b0;
        drive(1'b0, 8'h00, 32'h0);
        #1;
        chk_reset("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_reset.up_ready", 32'(up_if.ready), 32'd1);
        chk_out("post_reset", 1'b0, 8'h00, 32'h0, 2'd0);

        // ---- streaming, dn_ready=1 ----
        dn_if.ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'h01, 32'hA0 + 32'(i));
            tick();
            chk_out($sformatf("stream%0d", i), 1'b1, 8'h01, 32'hA0 + 32'(i), 2'd1);
            chk($sformatf("stream%0d.up_ready", i), 32'(up_if.ready), 32'd1);
        end
        drive(1'b0, 8'h00, 32'h0);
        tick();
        chk_out("stream_drain", 1'b0, 8'h00, 32'hA7, 2'd0);
        chk("stream.stall_cnt", 32'(stall_cnt), 32'd0);

`ifdef PIPE_SKID_EN
        // ---- back-pressure into the skid buffer ----
        dn_if.ready = 1'b0;
        drive(1'b1, 8'h02, 32'hB0);
        tick();
        chk_out("bp1", 1'b1, 8'h02, 32'hB0, 2'd1);
        drive(1'b1, 8'h03, 32'hB1);
        tick();
        chk_out("bp2", 1'b1, 8'h02, 32'hB0, 2'd2);
        chk("bp2.up_ready", 32'(up_if.ready), 32'd0);
        drive(1'b1, 8'h04, 32'hB2);
        tick();
        chk_out("bp3", 1'b1, 8'h02, 32'hB0, 2'd2);
        tick();
        chk_out("bp4", 1'b1, 8'h02, 32'hB0, 2'd2);
        chk("bp4.up_ready", 32'(up_if.ready), 32'd0);
        chk("bp4.stall_cnt", 32'(stall_cnt), 32'd3);
        dn_if.ready = 1'b1;
        tick();
        chk_out("bp5", 1'b1, 8'h03, 32'hB1, 2'd1);
        chk("bp5.up_ready", 32'(up_if.ready), 32'd1);
        tick();
        chk_out("bp6", 1'b1, 8'h04, 32'hB2, 2'd1);
        drive(1'b0, 8'h00, 32'h0);
        tick();
        chk_out("bp_drain", 1'b0, 8'h00, 32'hB2, 2'd0);
        chk("bp.stall_cnt", 32'(stall_cnt), 32'd3);

        // ---- flush while holding two entries, with an offer ----
        dn_if.ready = 1'b0;
        drive(1'b1, 8'h05, 32'hC0);
        tick();
        drive(1'b1, 8'h06, 32'hC1);
        tick();
        chk_out("pre_flush", 1'b1, 8'h05, 32'hC0, 2'd2);
        chk("pre_flush.stall_cnt", 32'(stall_cnt), 32'd4);
        drive(1'b1, 8'h07, 32'hC5);
        dn_if.ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 8'h00, 32'h0);
        chk_out("flush", 1'b0, 8'h00, 32'hC0, 2'd0);
        chk("flush.up_ready", 32'(up_if.ready), 32'd1);
        chk("flush.stall_cnt", 32'(stall_cnt), 32'd4);
        tick();
        chk_out("post_flush", 1'b0, 8'h00, 32'hC0, 2'd0);
`else
        // ---- back-pressure, single register; up_ready follows dn_ready ----
        dn_if.ready = 1'b0;
        drive(1'b1, 8'h02, 32'hB0);
        tick();
        chk_out("bp1", 1'b1, 8'h02, 32'hB0, 2'd1);
        chk("bp1.up_ready", 32'(up_if.ready), 32'd0);
        drive(1'b1, 8'h03, 32'hB1);
        tick();
        chk_out("bp2", 1'b1, 8'h02, 32'hB0, 2'd1);
        dn_if.ready = 1'b1;
        #1;
        chk("toggle_hi.up_ready", 32'(up_if.ready), 32'd1);
        dn_if.ready = 1'b0;
        #1;
        chk("toggle_lo.up_ready", 32'(up_if.ready), 32'd0);
        tick();
        chk_out("bp3", 1'b1, 8'h02, 32'hB0, 2'd1);
        chk("bp3.stall_cnt", 32'(stall_cnt), 32'd2);
        dn_if.ready = 1'b1;
        tick();
        chk_out("bp4", 1'b1, 8'h03, 32'hB1, 2'd1);
        drive(1'b0, 8'h00, 32'h0);
        tick();
        chk_out("bp_drain", 1'b0, 8'h00, 32'hB1, 2'd0);
        chk("bp.stall_cnt", 32'(stall_cnt), 32'd2);

        // ---- flush while holding one entry, with an acceptable offer ----
        dn_if.ready = 1'b0;
        drive(1'b1, 8'h05, 32'hC0);
        tick();
        chk_out("pre_flush", 1'b1, 8'h05, 32'hC0, 2'd1);
        drive(1'b1, 8'h07, 32'hC5);
        dn_if.ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 8'h00, 32'h0);
        chk_out("flush", 1'b0, 8'h00, 32'hC0, 2'd0);
        chk("flush.up_ready", 32'(up_if.ready), 32'd1);
        chk("flush.stall_cnt", 32'(stall_cnt), 32'd2);
        tick();
        chk_out("post_flush", 1'b0, 8'h00, 32'hC0, 2'd0);
`endif

        // ---- stall counter saturation ----
        begin
            int s0;
`ifdef PIPE_SKID_EN
            s0 = 4;
`else
            s0 = 2;
`endif
            dn_if.ready = 1'b0;
            drive(1'b1, 8'h08, 32'hE0);
            tick();
            drive(1'b0, 8'h00, 32'h0);
            for (int k = 1; k <= 21; k++) begin
                tick();
                chk($sformatf("sat%0d.stall_cnt", k), 32'(stall_cnt),
                    32'((s0 + k > 15) ? 15 : s0 + k));
            end
            chk_out("sat_hold", 1'b1, 8'h08, 32'hE0, 2'd1);
        end

        // ---- reset in the middle of operation ----
        drive(1'b1, 8'h09, 32'hE1);
        tick();
`ifdef PIPE_SKID_EN
        chk("pre_rst.occupancy", 32'(occupancy), 32'd2);
`else
        chk("pre_rst.occupancy", 32'(occupancy), 32'd1);
`endif
        rst = 1'b1;
        #1;
        chk_reset("mid_rst");
        dn_if.ready = 1'b1;
        tick();
        chk_reset("mid_rst_edge");
        rst = 1'b0;
        drive(1'b0, 8'h00, 32'h0);
        tick();
        chk("rst_exit.up_ready", 32'(up_if.ready), 32'd1);
        drive(1'b1, 8'h0A, 32'hD0);
        tick();
        chk_out("d0", 1'b1, 8'h0A, 32'hD0, 2'd1);
        drive(1'b0, 8'h00, 32'h0);
        tick();
        chk_out("d0_drain", 1'b0, 8'h00, 32'hD0, 2'd0);
        tick();
        chk_out("no_stale", 1'b0, 8'h00, 32'hD0, 2'd0);
        chk("end.stall_cnt", 32'(stall_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
